// File: rtl/mips_pkg.sv
// Shared definitions for the mips32 hazard/stall control slice.
// Stall lengths are counted in cycles that idexFlush is held high.
package mips_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    localparam int STALL_LOAD_BR = 2;
    localparam int STALL_ALU_BR  = 1;
    localparam int STALL_LOAD    = 1;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_reg_match.sv
// Flags a RAW dependency of one ID source register on one later-stage destination.
// Purely combinational; writes to r0 never count as a dependency.
module hazard_reg_match
    import mips_pkg::*;
(
    input  logic [4:0] src,
    input  logic       src_use,
    input  logic [4:0] dest,
    input  logic       we,
    output logic       hit
);

    assign hit = src_use & we & (dest != REG_ZERO) & (src == dest);

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller: stalls and flushes assert in the same cycle the hazard is seen.
// memStall freezes the whole pipe and holds all internal state until it drops.
module hazard_stall_unit
    import mips_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int MAX_STALL = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       rsID,
    input  logic [4:0]       rtID,
    input  logic             usesRsID,
    input  logic             usesRtID,
    input  logic             branchID,
    input  logic             branchTakenID,
    input  logic             jumpID,
    input  logic [4:0]       destRegEX,
    input  logic             regWriteEX,
    input  logic             memReadEX,
    input  logic [4:0]       destRegMEM,
    input  logic             regWriteMEM,
    input  logic             memReadMEM,
    input  logic             memStall,
    output logic             pcWrite,
    output logic             ifidWrite,
    output logic             ifidFlush,
    output logic             idexFlush,
    output logic             pipeFreeze,
    output logic [CNT_W-1:0] stallCycles,
    output logic [CNT_W-1:0] flushCount
);

    localparam int CNT_SW = $clog2(MAX_STALL + 1);

    state_e            state_q, state_d;
    logic [CNT_SW-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0]  flush_count_q, flush_count_d;

    logic              rs_ex_hit, rt_ex_hit, rs_mem_hit, rt_mem_hit;
    logic              ex_hit, mem_hit;
    logic [CNT_SW-1:0] need;
    logic              stall;

    hazard_reg_match u_rs_ex  (.src(rsID), .src_use(usesRsID), .dest(destRegEX),
                               .we(regWriteEX),  .hit(rs_ex_hit));
    hazard_reg_match u_rt_ex  (.src(rtID), .src_use(usesRtID), .dest(destRegEX),
                               .we(regWriteEX),  .hit(rt_ex_hit));
    hazard_reg_match u_rs_mem (.src(rsID), .src_use(usesRsID), .dest(destRegMEM),
                               .we(regWriteMEM), .hit(rs_mem_hit));
    hazard_reg_match u_rt_mem (.src(rtID), .src_use(usesRtID), .dest(destRegMEM),
                               .we(regWriteMEM), .hit(rt_mem_hit));

    assign ex_hit  = rs_ex_hit | rt_ex_hit;
    assign mem_hit = rs_mem_hit | rt_mem_hit;

    // Branches compare in ID, so they also wait on results forwarding cannot deliver in time.
    always_comb begin
        need = '0;
        if (branchID && ex_hit && memReadEX) begin
            need = CNT_SW'(STALL_LOAD_BR);
        end else if (branchID && ex_hit) begin
            need = CNT_SW'(STALL_ALU_BR);
        end else if (branchID && mem_hit && memReadMEM) begin
            need = CNT_SW'(STALL_ALU_BR);
        end else if (!branchID && ex_hit && memReadEX) begin
            need = CNT_SW'(STALL_LOAD);
        end
    end

    assign stall = (state_q == ST_HOLD) || (need != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_RUN;
            cnt_q          <= '0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!memStall) begin
            case (state_q)
                ST_RUN: begin
                    if (need > CNT_SW'(1)) begin
                        state_d = ST_HOLD;
                        cnt_d   = need - CNT_SW'(1);
                    end
                end
                ST_HOLD: begin
                    cnt_d   = (cnt_q == '0) ? '0 : cnt_q - CNT_SW'(1);
                    state_d = (cnt_d == '0) ? ST_RUN : ST_HOLD;
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        pcWrite    = 1'b1;
        ifidWrite  = 1'b1;
        ifidFlush  = 1'b0;
        idexFlush  = 1'b0;
        pipeFreeze = 1'b0;
        if (reset) begin
            pcWrite   = 1'b0;
            ifidWrite = 1'b0;
            ifidFlush = 1'b1;
            idexFlush = 1'b1;
        end else if (memStall) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            pipeFreeze = 1'b1;
        end else if (stall) begin
            pcWrite   = 1'b0;
            ifidWrite = 1'b0;
            idexFlush = 1'b1;
        end else if (branchTakenID || jumpID) begin
            ifidFlush = 1'b1;
        end
    end

    assign stall_cycles_d = stall_cycles_q + CNT_W'(idexFlush);
    assign flush_count_d  = flush_count_q + CNT_W'(ifidFlush);
    assign stallCycles    = stall_cycles_q;
    assign flushCount     = flush_count_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed and random stimulus against a cycle-level reference model; a monitor checks every cycle.
module tb_hazard_stall_unit;

    localparam int CNT_W = 4;
    localparam int CMASK = (1 << CNT_W) - 1;

    logic             clock;
    logic             reset;
    logic [4:0]       rsID, rtID, destRegEX, destRegMEM;
    logic             usesRsID, usesRtID, branchID, branchTakenID, jumpID;
    logic             regWriteEX, memReadEX, regWriteMEM, memReadMEM, memStall;
    logic             pcWrite, ifidWrite, ifidFlush, idexFlush, pipeFreeze;
    logic [CNT_W-1:0] stallCycles, flushCount;

    hazard_stall_unit #(.CNT_W(CNT_W), .MAX_STALL(2)) dut (
        .clock(clock), .reset(reset),
        .rsID(rsID), .rtID(rtID), .usesRsID(usesRsID), .usesRtID(usesRtID),
        .branchID(branchID), .branchTakenID(branchTakenID), .jumpID(jumpID),
        .destRegEX(destRegEX), .regWriteEX(regWriteEX), .memReadEX(memReadEX),
        .destRegMEM(destRegMEM), .regWriteMEM(regWriteMEM), .memReadMEM(memReadMEM),
        .memStall(memStall),
        .pcWrite(pcWrite), .ifidWrite(ifidWrite), .ifidFlush(ifidFlush),
        .idexFlush(idexFlush), .pipeFreeze(pipeFreeze),
        .stallCycles(stallCycles), .flushCount(flushCount)
    );

    typedef struct {
        logic [4:0] rs, rt, dex, dmem;
        logic       urs, urt, br, tk, jmp, wex, mex, wmem, mmem, mst, rst;
    } stim_t;

    // ctl = {pcWrite, ifidWrite, ifidFlush, idexFlush, pipeFreeze}
    typedef struct {
        logic [4:0] ctl;
        int         sc;
        int         fc;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle_no = 0;
    int   stall_left = 0;
    int   m_sc = 0;
    int   m_fc = 0;

    initial clock = 1'b1;
    always #5 clock = ~clock;

    function automatic bit dep(logic [4:0] a, logic u, logic [4:0] d, logic we);
        return u && we && (d != 5'd0) && (a == d);
    endfunction

    function automatic int ref_need(stim_t s);
        bit ex_dep, mem_dep;
        ex_dep  = dep(s.rs, s.urs, s.dex, s.wex) || dep(s.rt, s.urt, s.dex, s.wex);
        mem_dep = dep(s.rs, s.urs, s.dmem, s.wmem) || dep(s.rt, s.urt, s.dmem, s.wmem);
        if (s.br) begin
            if (ex_dep) return s.mex ? 2 : 1;
            if (mem_dep && s.mmem) return 1;
            return 0;
        end
        return (ex_dep && s.mex) ? 1 : 0;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{rs: 5'd0, rt: 5'd0, dex: 5'd0, dmem: 5'd0, urs: 1'b0, urt: 1'b0, br: 1'b0,
              tk: 1'b0, jmp: 1'b0, wex: 1'b0, mex: 1'b0, wmem: 1'b0, mmem: 1'b0,
              mst: 1'b0, rst: 1'b0};
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rs = 5'($urandom_range(0, 3));  s.rt = 5'($urandom_range(0, 3));
        s.dex = 5'($urandom_range(0, 3)); s.dmem = 5'($urandom_range(0, 3));
        s.urs = 1'($urandom); s.urt = 1'($urandom); s.br = 1'($urandom);
        s.tk = 1'($urandom_range(0, 3) == 0); s.jmp = 1'($urandom_range(0, 7) == 0);
        s.wex = 1'($urandom); s.mex = 1'($urandom); s.wmem = 1'($urandom); s.mmem = 1'($urandom);
        s.mst = 1'($urandom_range(0, 7) == 0);
        s.rst = 1'($urandom_range(0, 63) == 0);
        return s;
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        int   n;
        rsID = s.rs; rtID = s.rt; usesRsID = s.urs; usesRtID = s.urt;
        branchID = s.br; branchTakenID = s.tk; jumpID = s.jmp;
        destRegEX = s.dex; regWriteEX = s.wex; memReadEX = s.mex;
        destRegMEM = s.dmem; regWriteMEM = s.wmem; memReadMEM = s.mmem;
        memStall = s.mst; reset = s.rst;
        e.sc = m_sc; e.fc = m_fc; e.cyc = cycle_no;
        if (s.rst) begin
            e.ctl = 5'b00110;
            stall_left = 0; m_sc = 0; m_fc = 0;
        end else if (s.mst) begin
            e.ctl = 5'b00001;
        end else if (stall_left > 0) begin
            e.ctl = 5'b00010;
            stall_left--;
            m_sc = (m_sc + 1) & CMASK;
        end else begin
            n = ref_need(s);
            if (n > 0) begin
                e.ctl = 5'b00010;
                stall_left = n - 1;
                m_sc = (m_sc + 1) & CMASK;
            end else if (s.tk || s.jmp) begin
                e.ctl = 5'b11100;
                m_fc = (m_fc + 1) & CMASK;
            end else begin
                e.ctl = 5'b11000;
            end
        end
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        cycle_no++;
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [4:0] ctl;
            e = exp_q.pop_front();
            ctl = {pcWrite, ifidWrite, ifidFlush, idexFlush, pipeFreeze};
            checks++;
            if (ctl !== e.ctl) begin
                errors++;
                $display("FAIL ctl cycle %0d got %b expected %b", e.cyc, ctl, e.ctl);
            end
            checks++;
            if (stallCycles !== CNT_W'(e.sc)) begin
                errors++;
                $display("FAIL stallCycles cycle %0d got %0d expected %0d", e.cyc, stallCycles, e.sc);
            end
            checks++;
            if (flushCount !== CNT_W'(e.fc)) begin
                errors++;
                $display("FAIL flushCount cycle %0d got %0d expected %0d", e.cyc, flushCount, e.fc);
            end
        end
    end

    initial begin
        stim_t s;
        #1;
        s = idle(); s.rst = 1'b1;
        step(s); step(s);
        // load-use on rs: one stall then normal
        s = idle(); s.dex = 5'd2; s.wex = 1'b1; s.mex = 1'b1; s.rs = 5'd2; s.urs = 1'b1;
        step(s); step(idle());
        // load then branch on rt: two stalls, inputs in the second one ignored
        s = idle(); s.dex = 5'd3; s.wex = 1'b1; s.mex = 1'b1; s.rt = 5'd3; s.urt = 1'b1; s.br = 1'b1;
        step(s);
        s = idle(); s.br = 1'b1; s.tk = 1'b1; s.jmp = 1'b1;
        step(s); step(s);
        // ALU result feeding a branch: one stall, then taken flush
        s = idle(); s.dex = 5'd4; s.wex = 1'b1; s.rs = 5'd4; s.urs = 1'b1; s.br = 1'b1;
        step(s);
        s = idle(); s.dmem = 5'd4; s.wmem = 1'b1; s.rs = 5'd4; s.urs = 1'b1; s.br = 1'b1; s.tk = 1'b1;
        step(s);
        // branch after a load in MEM stalls once; branch after ALU op in MEM does not
        s = idle(); s.dmem = 5'd6; s.wmem = 1'b1; s.mmem = 1'b1; s.rt = 5'd6; s.urt = 1'b1; s.br = 1'b1;
        step(s);
        s.mmem = 1'b0;
        step(s);
        // r0 destination never stalls; jump flushes the same cycle
        s = idle(); s.wex = 1'b1; s.mex = 1'b1; s.urs = 1'b1;
        step(s);
        s.jmp = 1'b1;
        step(s);
        // two-cycle stall interrupted by three memStall cycles
        s = idle(); s.dex = 5'd5; s.wex = 1'b1; s.mex = 1'b1; s.rs = 5'd5; s.urs = 1'b1; s.br = 1'b1;
        step(s);
        s.mst = 1'b1;
        step(s); step(s); step(s);
        step(idle()); step(idle());
        // reset in the middle of a two-cycle stall
        s = idle(); s.dex = 5'd7; s.wex = 1'b1; s.mex = 1'b1; s.rt = 5'd7; s.urt = 1'b1; s.br = 1'b1;
        step(s);
        s = idle(); s.rst = 1'b1;
        step(s);
        step(idle());
        // enough single-cycle stalls to wrap the stall counter
        s = idle(); s.dex = 5'd1; s.wex = 1'b1; s.mex = 1'b1; s.rs = 5'd1; s.urs = 1'b1;
        for (int i = 0; i < 18; i++) step(s);
        for (int i = 0; i < 18; i++) begin
            s = idle(); s.jmp = 1'b1;
            step(s);
        end
        for (int i = 0; i < 3000; i++) step(rand_stim());
        step(idle());
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clock);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
